multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS-subset CPU; sits directly upstream of the datapath.
- Consumes the opcode and funct fields from the instruction register and the ALU zero flag.
- Drives every datapath write enable and mux select: PC, memory, IR, register bank, writedata/writereg muxes, ALU source muxes, PC source mux.
- Moore outputs decoded from the state register; the only exception is branch pc_write, which is gated by `zero`.

Parameters:
- MEM_WAIT, 1, memory read latency in cycles (legal 1..7); sizes the FETCH and MEM_READ wait counts.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset; one clock domain only
- opcode  in  6  instruction bits 31:26
- funct  in  6  instruction bits 5:0
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load
- pc_source  out  2  00 ALU result, 01 ALUout, 10 jump target, 11 exception vector
- iord  out  1  memory address select: 0 PC, 1 ALUout
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR load
- reg_write  out  1  register bank write
- mem_to_reg  out  1  writedata select: 1 memory data, 0 ALUout
- reg_dest  out  1  writereg select: 0 rt, 1 rd
- alu_src_a  out  1  0 PC, 1 ReadData1
- alu_src_b  out  2  00 ReadData2, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
- alu_op  out  3  ALU function code
- exc_illegal  out  1  illegal-opcode pulse
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - While reset==0 at a rising edge: state<=RESET, wait counter<=0.
  - In RESET all outputs are 0.
  - First edge with reset==1: RESET->FETCH.
  - Reset mid-instruction abandons the instruction. No write strobe asserts in the reset cycle or after it. The next instruction starts from FETCH.
- FETCH (1+MEM_WAIT cycles):
  - iord=0 throughout.
  - On the final cycle only: ir_write=1, pc_write=1, pc_source=00, alu_src_a=0, alu_src_b=01, alu_op=ADD (PC+4).
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD; branch target goes to ALUout. Dispatch on opcode:
  - 0x00 -> R_EXEC
  - 0x23, 0x2B -> MEM_ADDR
  - 0x04, 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> I_EXEC
  - any other -> ILLEGAL
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Unknown funct -> ADD. R-type is never illegal.
- R_WB: reg_write=1, reg_dest=1, mem_to_reg=0 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next: lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ (MEM_WAIT cycles): iord=1 -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dest=0 -> FETCH.
- MEM_WRITE (1 cycle): iord=1, mem_write=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01.
  - pc_write = zero for beq, !zero for bne.
  - -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD -> I_WB.
- I_WB: reg_write=1, reg_dest=0, mem_to_reg=0 -> FETCH.
- Any output not listed for a state is 0.
- Latency (cycles, MEM_WAIT=1): R 5, addi 5, lw 6, sw 5, beq/bne 4, j 4.
- Wait counter:
  - 3-bit, cleared on every state entry.
  - A wait state exits when the count reaches MEM_WAIT-1 (FETCH: MEM_WAIT, then the strobe cycle).
- Unreachable state encodings return to FETCH on the next edge with all outputs 0.

Optional Feature:
- MULTICYCLE_CTRL_TRAP_EN.
- Defined: ILLEGAL state lasts 1 cycle with pc_source=11, pc_write=1, exc_illegal=1, then -> FETCH.
- Undefined: ILLEGAL lasts 1 cycle, all outputs 0 (instruction treated as NOP), then -> FETCH. exc_illegal is tied 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encodings (4-bit)
  - opcode and funct constants
  - alu_op codes: ADD=001, SUB=010, AND=011, OR=100, SLT=101
  - pc_source and alu_src_b select codes
- One natural sub-module: ctrl_alu_decoder, combinational funct -> alu_op, used in R_EXEC.

Test Plan:
- Reset test:
  - Stimulus: reset=0 for 3 cycles, then 1.
  - Response: all outputs 0 and state_dbg=RESET during reset. FETCH follows. Cycle 2 of FETCH has ir_write=1, pc_write=1, alu_src_b=01, iord=0.
- Add test:
  - Stimulus: opcode 0x00, funct 0x20.
  - Response: FETCH,FETCH,DECODE,R_EXEC(alu_op=001),R_WB(reg_write=1, reg_dest=1), then FETCH. Repeat with funct 0x2A -> alu_op=101.
- Load/store test:
  - lw 0x23: 6 cycles, iord=1 in MEM_READ, MEM_WB has mem_to_reg=1.
  - sw 0x2B: mem_write high exactly 1 cycle. With MEM_WAIT=3, lw takes 10 cycles.
- Branch test:
  - beq 0x04, zero=1 -> pc_write=1, pc_source=01 in BRANCH.
  - beq, zero=0 -> pc_write=0.
  - bne 0x05, zero=0 -> pc_write=1.
- Reset mid-instruction:
  - Stimulus: reset=0 during MEM_ADDR of sw.
  - Response: mem_write never asserts; the next cycle after release is FETCH.
- Illegal opcode test:
  - Stimulus: opcode 0x3F.
  - With the macro: pc_source=11, pc_write=1, exc_illegal=1 for one cycle.
  - Without the macro: DECODE->ILLEGAL->FETCH with zero write strobes.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and output decode for the multicycle control FSM.
// MULTICYCLE_CTRL_TRAP_EN turns the ILLEGAL state into an exception-vector jump.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_R_EXEC    = 4'd3,
    ST_R_WB      = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WB    = 4'd7,
    ST_MEM_WRITE = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_I_EXEC    = 4'd11,
    ST_I_WB      = 4'd12,
    ST_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // br_en/br_ne let the top gate the branch PC load with the live zero flag
  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       exc_illegal;
    logic       br_en;
    logic       br_ne;
  } ctrl_t;

  function automatic ctrl_t state_outputs(input state_t s, input logic fetch_last,
                                          input logic [2:0] r_alu_op, input logic is_bne);
    ctrl_t o;
    o = '0;
    case (s)
      ST_FETCH: begin
        if (fetch_last) begin
          o.ir_write  = 1'b1;
          o.pc_write  = 1'b1;
          o.pc_source = PCS_ALU;
          o.alu_src_b = SRCB_FOUR;
          o.alu_op    = ALU_ADD;
        end else begin
          o.iord = 1'b0;
        end
      end
      ST_DECODE: begin
        o.alu_src_b = SRCB_IMM_SH;
        o.alu_op    = ALU_ADD;
      end
      ST_R_EXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_REG;
        o.alu_op    = r_alu_op;
      end
      ST_R_WB: begin
        o.reg_write = 1'b1;
        o.reg_dest  = 1'b1;
      end
      ST_MEM_ADDR, ST_I_EXEC: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_IMM;
        o.alu_op    = ALU_ADD;
      end
      ST_MEM_READ: o.iord = 1'b1;
      ST_MEM_WB: begin
        o.reg_write  = 1'b1;
        o.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        o.iord      = 1'b1;
        o.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        o.alu_src_a = 1'b1;
        o.alu_src_b = SRCB_REG;
        o.alu_op    = ALU_SUB;
        o.pc_source = PCS_ALUOUT;
        o.br_en     = 1'b1;
        o.br_ne     = is_bne;
      end
      ST_JUMP: begin
        o.pc_source = PCS_JUMP;
        o.pc_write  = 1'b1;
      end
      ST_I_WB: o.reg_write = 1'b1;
      ST_ILLEGAL: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        o.pc_source   = PCS_EXC;
        o.pc_write    = 1'b1;
        o.exc_illegal = 1'b1;
`else
        o = '0;
`endif
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct field to ALU function code; unknown functs fall back to ADD.
module ctrl_alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  // Pure lookup, no state
  always_comb begin
    alu_op = ALU_ADD;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with registered Moore outputs.
// Optional MULTICYCLE_CTRL_TRAP_EN makes illegal opcodes trap to the exception vector.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       exc_illegal,
  output logic [3:0] state_dbg
);

  localparam logic [2:0] FETCH_LAST = 3'(MEM_WAIT);
  localparam logic [2:0] READ_LAST  = 3'(MEM_WAIT - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] cnt_r;
  logic [2:0] cnt_nxt_s;
  ctrl_t      out_r;
  ctrl_t      out_nxt_s;
  logic [2:0] r_alu_op_s;

  ctrl_alu_decoder u_alu_dec (
    .funct  (funct),
    .alu_op (r_alu_op_s)
  );

  // Next-state dispatch and wait counter; outputs are decoded for the state being entered
  always_comb begin
    state_nxt_s = ST_FETCH;
    case (state_r)
      ST_RESET: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        if (cnt_r == FETCH_LAST) state_nxt_s = ST_DECODE;
        else                     state_nxt_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_nxt_s = ST_R_EXEC;
          OP_LW, OP_SW: state_nxt_s = ST_MEM_ADDR;
          OP_BEQ, OP_BNE: state_nxt_s = ST_BRANCH;
          OP_J:         state_nxt_s = ST_JUMP;
          OP_ADDI:      state_nxt_s = ST_I_EXEC;
          default:      state_nxt_s = ST_ILLEGAL;
        endcase
      end
      ST_R_EXEC: state_nxt_s = ST_R_WB;
      ST_MEM_ADDR: begin
        if (opcode == OP_LW) state_nxt_s = ST_MEM_READ;
        else                 state_nxt_s = ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        if (cnt_r == READ_LAST) state_nxt_s = ST_MEM_WB;
        else                    state_nxt_s = ST_MEM_READ;
      end
      ST_I_EXEC: state_nxt_s = ST_I_WB;
      default:   state_nxt_s = ST_FETCH;
    endcase

    if (state_nxt_s != state_r) cnt_nxt_s = 3'd0;
    else                        cnt_nxt_s = cnt_r + 3'd1;

    out_nxt_s = state_outputs(state_nxt_s,
                              (state_nxt_s == ST_FETCH) && (cnt_nxt_s == FETCH_LAST),
                              r_alu_op_s, opcode == OP_BNE);
  end

  // State, wait counter and control outputs all clear together under reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_RESET;
      cnt_r   <= 3'd0;
      out_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  assign pc_write    = out_r.pc_write | (out_r.br_en & (zero ^ out_r.br_ne));
  assign pc_source   = out_r.pc_source;
  assign iord        = out_r.iord;
  assign mem_write   = out_r.mem_write;
  assign ir_write    = out_r.ir_write;
  assign reg_write   = out_r.reg_write;
  assign mem_to_reg  = out_r.mem_to_reg;
  assign reg_dest    = out_r.reg_dest;
  assign alu_src_a   = out_r.alu_src_a;
  assign alu_src_b   = out_r.alu_src_b;
  assign alu_op      = out_r.alu_op;
  assign exc_illegal = out_r.exc_illegal;
  assign state_dbg   = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle bench for multicycle_control (MEM_WAIT=1 main DUT, MEM_WAIT=3 lw-only DUT).
module tb_multicycle_control;

  localparam logic [3:0] S_RESET = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,
                         S_R_EXEC = 4'd3, S_R_WB = 4'd4,   S_MEM_ADDR = 4'd5,
                         S_MEM_READ = 4'd6, S_MEM_WB = 4'd7, S_MEM_WRITE = 4'd8,
                         S_BRANCH = 4'd9, S_JUMP = 4'd10,  S_I_EXEC = 4'd11,
                         S_I_WB = 4'd12,  S_ILLEGAL = 4'd13;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct, opcode3;
  logic zero;

  logic pc_write, iord, mem_write, ir_write, reg_write, mem_to_reg, reg_dest, alu_src_a, exc_illegal;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_dbg;

  logic pc_write3, iord3, mem_write3, ir_write3, reg_write3, mem_to_reg3, reg_dest3, alu_src_a3, exc_illegal3;
  logic [1:0] pc_source3, alu_src_b3;
  logic [2:0] alu_op3;
  logic [3:0] state_dbg3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_write(pc_write), .pc_source(pc_source), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .reg_dest(reg_dest),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .exc_illegal(exc_illegal), .state_dbg(state_dbg)
  );

  multicycle_control #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .opcode(opcode3), .funct(funct), .zero(zero),
    .pc_write(pc_write3), .pc_source(pc_source3), .iord(iord3), .mem_write(mem_write3),
    .ir_write(ir_write3), .reg_write(reg_write3), .mem_to_reg(mem_to_reg3), .reg_dest(reg_dest3),
    .alu_src_a(alu_src_a3), .alu_src_b(alu_src_b3), .alu_op(alu_op3),
    .exc_illegal(exc_illegal3), .state_dbg(state_dbg3)
  );

  // Output vector order: pw, pcs[2], iord, mw, irw, rw, m2r, rd, sa, sb[2], op[3], exc
  function automatic logic [15:0] mk(input logic pw, input logic [1:0] pcs, input logic io,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic m2r, input logic rd, input logic sa,
                                     input logic [1:0] sb, input logic [2:0] op, input logic exc);
    return {pw, pcs, io, mw, irw, rw, m2r, rd, sa, sb, op, exc};
  endfunction

  function automatic logic [15:0] obs();
    return {pc_write, pc_source, iord, mem_write, ir_write, reg_write, mem_to_reg, reg_dest,
            alu_src_a, alu_src_b, alu_op, exc_illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cyc(input string tag, input logic [3:0] st, input logic [15:0] ev);
    chk({tag, ".state"}, {28'd0, state_dbg}, {28'd0, st});
    chk({tag, ".outs"}, {16'd0, obs()}, {16'd0, ev});
  endtask

  task automatic exp_cyc(input string tag, input logic [3:0] st, input logic [15:0] ev);
    chk_cyc(tag, st, ev);
    step();
  endtask

  logic [15:0] v_f0, v_f1, v_dec, v_radd, v_rslt, v_rwb, v_madr, v_mrd, v_mwb, v_mwr;
  logic [15:0] v_br1, v_br0, v_jmp, v_iex, v_iwb, v_ill;

  // Common FETCH/FETCH/DECODE prefix of every instruction
  task automatic instr(input string tag, input logic [5:0] opc, input logic [5:0] fn, input logic z);
    opcode = opc;
    funct  = fn;
    zero   = z;
    exp_cyc({tag, ".f0"}, S_FETCH, v_f0);
    exp_cyc({tag, ".f1"}, S_FETCH, v_f1);
    exp_cyc({tag, ".dec"}, S_DECODE, v_dec);
  endtask

  initial begin
    int cyc;
    int rd_cyc;
    bit left;
    v_f0   = 16'd0;
    v_f1   = mk(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 3'b001, 1'b0);
    v_dec  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 3'b001, 1'b0);
    v_radd = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001, 1'b0);
    v_rslt = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b101, 1'b0);
    v_rwb  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    v_madr = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 3'b001, 1'b0);
    v_mrd  = mk(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    v_mwb  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    v_mwr  = mk(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    v_br1  = mk(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0);
    v_br0  = mk(1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0);
    v_jmp  = mk(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    v_iex  = v_madr;
    v_iwb  = mk(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    v_ill  = mk(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b1);
`else
    v_ill  = 16'd0;
`endif

    reset = 1'b0; opcode = 6'h00; funct = 6'h20; zero = 1'b0; opcode3 = 6'h23;

    // Reset held low for three cycles, all outputs quiet
    step();
    for (int i = 0; i < 3; i++) exp_cyc("rst", S_RESET, 16'd0);
    reset = 1'b1;
    exp_cyc("rst.rel", S_RESET, 16'd0);

    // R-type add then slt
    instr("add", 6'h00, 6'h20, 1'b0);
    exp_cyc("add.ex", S_R_EXEC, v_radd);
    exp_cyc("add.wb", S_R_WB, v_rwb);
    instr("slt", 6'h00, 6'h2A, 1'b0);
    exp_cyc("slt.ex", S_R_EXEC, v_rslt);
    exp_cyc("slt.wb", S_R_WB, v_rwb);

    // Load and store
    instr("lw", 6'h23, 6'h00, 1'b0);
    exp_cyc("lw.adr", S_MEM_ADDR, v_madr);
    exp_cyc("lw.rd", S_MEM_READ, v_mrd);
    exp_cyc("lw.wb", S_MEM_WB, v_mwb);
    instr("sw", 6'h2B, 6'h00, 1'b0);
    exp_cyc("sw.adr", S_MEM_ADDR, v_madr);
    exp_cyc("sw.wr", S_MEM_WRITE, v_mwr);

    // Branches under both zero polarities
    instr("beq1", 6'h04, 6'h00, 1'b1);
    exp_cyc("beq1.br", S_BRANCH, v_br1);
    instr("beq0", 6'h04, 6'h00, 1'b0);
    exp_cyc("beq0.br", S_BRANCH, v_br0);
    instr("bne0", 6'h05, 6'h00, 1'b0);
    exp_cyc("bne0.br", S_BRANCH, v_br1);
    instr("bne1", 6'h05, 6'h00, 1'b1);
    exp_cyc("bne1.br", S_BRANCH, v_br0);

    // Jump, addi, illegal opcode
    instr("j", 6'h02, 6'h00, 1'b0);
    exp_cyc("j.jmp", S_JUMP, v_jmp);
    instr("addi", 6'h08, 6'h00, 1'b0);
    exp_cyc("addi.ex", S_I_EXEC, v_iex);
    exp_cyc("addi.wb", S_I_WB, v_iwb);
    instr("ill", 6'h3F, 6'h00, 1'b0);
    exp_cyc("ill.st", S_ILLEGAL, v_ill);

    // Reset during MEM_ADDR of sw abandons the store
    instr("swrst", 6'h2B, 6'h00, 1'b0);
    chk_cyc("swrst.adr", S_MEM_ADDR, v_madr);
    reset = 1'b0;
    step();
    chk_cyc("swrst.rst", S_RESET, 16'd0);
    reset = 1'b1;
    step();
    exp_cyc("swrst.f0", S_FETCH, v_f0);
    chk("swrst.mw", {31'd0, mem_write}, 32'd0);

    // MEM_WAIT=3 instance: lw takes 10 cycles with 3 MEM_READ cycles
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("lw3.start", {28'd0, state_dbg3}, {28'd0, S_FETCH});
    cyc = 1; rd_cyc = 0; left = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (state_dbg3 != S_FETCH) begin
        left = 1'b1;
        if (state_dbg3 == S_MEM_READ) begin
          rd_cyc++;
          chk("lw3.iord", {31'd0, iord3}, 32'd1);
        end
      end else if (left) begin
        break;
      end
      cyc++;
    end
    chk("lw3.cycles", cyc, 10);
    chk("lw3.rdcyc", rd_cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
